// File: rtl/ble_rx_pkg.sv
// Shared types and constants for the BLE receive chain.
// Used by the packet framing stage and its interface.
package ble_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    HEADER,
    PAYLOAD,
    DONE
  } pkt_state_t;

  localparam logic [31:0] BLE_ADV_AA = 32'h8E89BED6;
  localparam int AA_LEN  = 32;
  localparam int HDR_LEN = 16;

endpackage

// File: rtl/packet_sync_if.sv
// Bit-stream input and framed-packet output bundle
// between preamble detector, packet_sync and dewhitener.
interface packet_sync_if;
  import ble_rx_pkg::*;

  logic               en;
  logic               data_bit;
  logic               preamble_detected;
  logic               aa_match;
  logic [HDR_LEN-1:0] header;
  logic               bit_out;
  logic               bit_valid;
  logic               pkt_done;
  logic               pkt_abort;

  modport master (
    output en,
    output data_bit,
    output preamble_detected,
    input  aa_match,
    input  header,
    input  bit_out,
    input  bit_valid,
    input  pkt_done,
    input  pkt_abort
  );

  modport slave (
    input  en,
    input  data_bit,
    input  preamble_detected,
    output aa_match,
    output header,
    output bit_out,
    output bit_valid,
    output pkt_done,
    output pkt_abort
  );

endinterface

// File: rtl/bit_sampler.sv
// Mid-bit sample strobe generator for the oversampled
// bit stream; restarted on every preamble detect.
module bit_sampler #(
  parameter int SAMPLE_RATE = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic start,
  output logic strobe
);

  localparam int PW = $clog2(SAMPLE_RATE);

  logic [PW-1:0] phase_q, phase_d;

  // Count down per enabled cycle; strobe and reload at zero.
  always_comb begin
    phase_d = phase_q;
    strobe  = 1'b0;
    if (en) begin
      if (start) begin
        phase_d = PW'(SAMPLE_RATE/2 - 2);
      end else if (phase_q == '0) begin
        strobe  = 1'b1;
        phase_d = PW'(SAMPLE_RATE - 1);
      end else begin
        phase_d = phase_q - PW'(1);
      end
    end
  end

  // Phase register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) phase_q <= '0;
    else         phase_q <= phase_d;
  end

endmodule

// File: rtl/packet_sync.sv
// BLE packet framing: access-address correlation, header
// capture and payload/CRC bit streaming.
module packet_sync
  import ble_rx_pkg::*;
#(
  parameter int          SAMPLE_RATE = 16,
  parameter logic [31:0] ACCESS_ADDR = BLE_ADV_AA,
  parameter int          AA_ERRORS   = 1,
  parameter int          MAX_LEN     = 37,
  parameter int          CRC_BITS    = 24
) (
  input logic         clk,
  input logic         resetn,
  packet_sync_if.slave rx
);

  pkt_state_t         state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [AA_LEN-2:0]  aa_sr_q, aa_sr_d;
  logic [HDR_LEN-2:0] hdr_sr_q, hdr_sr_d;
  logic [11:0]        rem_q, rem_d;
  logic [HDR_LEN-1:0] header_q, header_d;
  logic               aa_match_q, aa_match_d;
  logic               bit_out_q, bit_out_d;
  logic               bit_valid_q, bit_valid_d;
  logic               pkt_done_q, pkt_done_d;
  logic               pkt_abort_q, pkt_abort_d;

  logic               start;
  logic               strobe;
  logic [AA_LEN-1:0]  aa_word;
  logic [HDR_LEN-1:0] hdr_word;
  logic [7:0]         len;
  logic [11:0]        rem_load;
  logic               aa_ok;

  function automatic int popcount(input logic [AA_LEN-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < AA_LEN; i++) n += int'(v[i]);
    return n;
  endfunction

  bit_sampler #(
    .SAMPLE_RATE(SAMPLE_RATE)
  ) u_sampler (
    .clk   (clk),
    .resetn(resetn),
    .en    (rx.en),
    .start (start),
    .strobe(strobe)
  );

  assign start    = rx.en & rx.preamble_detected
                  & (state_q == IDLE);
  assign aa_word  = {rx.data_bit, aa_sr_q};
  assign hdr_word = {rx.data_bit, hdr_sr_q};
  assign len      = hdr_word[15:8];
  assign rem_load = 12'({len, 3'b000}) + 12'(CRC_BITS);
  assign aa_ok    = popcount(aa_word ^ ACCESS_ADDR)
                  <= AA_ERRORS;

  // Framing FSM: next state, shift registers, output pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    aa_sr_d     = aa_sr_q;
    hdr_sr_d    = hdr_sr_q;
    rem_d       = rem_q;
    header_d    = header_q;
    aa_match_d  = 1'b0;
    bit_out_d   = 1'b0;
    bit_valid_d = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_abort_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (strobe) begin
          aa_sr_d = aa_word[AA_LEN-1:1];
          if (cnt_q == 6'(AA_LEN - 1)) begin
            cnt_d = '0;
            if (aa_ok) begin
              aa_match_d = 1'b1;
              state_d    = HEADER;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      HEADER: begin
        if (strobe) begin
          hdr_sr_d = hdr_word[HDR_LEN-1:1];
          if (cnt_q == 6'(HDR_LEN - 1)) begin
            cnt_d    = '0;
            header_d = hdr_word;
            if (len > 8'(MAX_LEN)) begin
              pkt_abort_d = 1'b1;
              state_d     = IDLE;
            end else begin
              rem_d   = rem_load;
              state_d = (rem_load == '0) ? DONE : PAYLOAD;
            end
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      PAYLOAD: begin
        if (strobe) begin
          bit_valid_d = 1'b1;
          bit_out_d   = rx.data_bit;
          rem_d       = rem_q - 12'd1;
          if (rem_q == 12'd1) state_d = DONE;
        end
      end
      DONE: begin
        pkt_done_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops everything.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      aa_sr_q     <= '0;
      hdr_sr_q    <= '0;
      rem_q       <= '0;
      header_q    <= '0;
      aa_match_q  <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      aa_sr_q     <= aa_sr_d;
      hdr_sr_q    <= hdr_sr_d;
      rem_q       <= rem_d;
      header_q    <= header_d;
      aa_match_q  <= aa_match_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      pkt_done_q  <= pkt_done_d;
      pkt_abort_q <= pkt_abort_d;
    end
  end

  assign rx.aa_match  = aa_match_q;
  assign rx.header    = header_q;
  assign rx.bit_out   = bit_out_q;
  assign rx.bit_valid = bit_valid_q;
  assign rx.pkt_done  = pkt_done_q;
  assign rx.pkt_abort = pkt_abort_q;

endmodule

// File: tb/tb_packet_sync.sv
// Directed bench for packet_sync: framing, AA tolerance,
// length abort, enable gating, re-detect and reset.
module tb_packet_sync;
  import ble_rx_pkg::*;

  localparam int SR = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  packet_sync_if bus();

  packet_sync #(
    .SAMPLE_RATE(SR),
    .ACCESS_ADDR(BLE_ADV_AA),
    .AA_ERRORS  (1),
    .MAX_LEN    (37),
    .CRC_BITS   (24)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .rx    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int unsigned cyc = 0;
  int unsigned n_aa = 0, n_val = 0, n_done = 0;
  int unsigned n_abort = 0, n_gap = 0, n_ovl = 0;
  int unsigned prev_v = 0;
  int unsigned exp_gap = SR;
  bit          have_prev = 1'b0;
  bit          rx_q[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.aa_match)  n_aa <= n_aa + 1;
    if (bus.pkt_done)  n_done <= n_done + 1;
    if (bus.pkt_abort) n_abort <= n_abort + 1;
    if (bus.bit_valid && (bus.aa_match || bus.pkt_abort))
      n_ovl <= n_ovl + 1;
    if (bus.bit_valid) begin
      n_val <= n_val + 1;
      rx_q.push_back(bus.bit_out);
      if (have_prev && (cyc - prev_v != exp_gap))
        n_gap <= n_gap + 1;
      prev_v    <= cyc;
      have_prev <= 1'b1;
    end
    if (bus.pkt_done || bus.pkt_abort || !resetn)
      have_prev <= 1'b0;
  end

  // Stimulus.
  bit         tog = 1'b0;
  bit         tx_q[$];
  bit         pay_q[$];
  logic [3:0] snap_q[$];
  int unsigned b_aa, b_val, b_done, b_abort;
  int          rx_base;

  function automatic int mism(input int base);
    int n;
    n = 0;
    for (int i = 0; i < pay_q.size(); i++) begin
      if (base + i >= rx_q.size()) n++;
      else if (rx_q[base+i] != pay_q[i]) n++;
    end
    return n;
  endfunction

  task automatic base();
    b_aa    = n_aa;
    b_val   = n_val;
    b_done  = n_done;
    b_abort = n_abort;
    rx_base = rx_q.size();
  endtask

  task automatic build(input logic [31:0] aa,
                       input logic [15:0] hdr,
                       input int pay_bits);
    logic [23:0] crc;
    logic [7:0]  bv;
    int          plen;
    crc  = 24'hC35AF0;
    plen = pay_bits - 24;
    tx_q.delete();
    pay_q.delete();
    for (int i = 0; i < 32; i++) tx_q.push_back(aa[i]);
    for (int i = 0; i < 16; i++) tx_q.push_back(hdr[i]);
    for (int k = 0; k < pay_bits; k++) begin
      bv = 8'(167 + 53 * (k / 8));
      if (k >= plen) begin
        tx_q.push_back(crc[k-plen]);
        pay_q.push_back(crc[k-plen]);
      end else begin
        tx_q.push_back(bv[k%8]);
        pay_q.push_back(bv[k%8]);
      end
    end
  endtask

  task automatic detect();
    @(negedge clk);
    bus.en = 1'b1;
    bus.preamble_detected = 1'b1;
    bus.data_bit = 1'b0;
    if (tog) begin
      @(negedge clk);
      bus.en = 1'b0;
      bus.preamble_detected = 1'b0;
    end
  endtask

  // One bit over SR enabled cycles; snapshot just after
  // the mid-bit strobe: {done(+1), aa, abort, valid}.
  task automatic send_bit(input bit b, input bit pre);
    logic [3:0] s;
    s = '0;
    for (int j = 0; j < SR; j++) begin
      @(negedge clk);
      if (!tog && j == SR/2 - 1)
        s[2:0] = {bus.aa_match, bus.pkt_abort, bus.bit_valid};
      if (!tog && j == SR/2)
        s[3] = bus.pkt_done;
      bus.en = 1'b1;
      bus.data_bit = b;
      bus.preamble_detected = pre && (j == 0);
      if (tog) begin
        @(negedge clk);
        if (j == SR/2 - 2)
          s[2:0] = {bus.aa_match, bus.pkt_abort, bus.bit_valid};
        bus.en = 1'b0;
        bus.preamble_detected = 1'b0;
      end
    end
    snap_q.push_back(s);
  endtask

  task automatic run(input logic [31:0] aa,
                     input logic [15:0] hdr,
                     input int pay_bits,
                     input int pre_at,
                     input int upto);
    build(aa, hdr, pay_bits);
    base();
    snap_q.delete();
    detect();
    for (int i = 0; i < tx_q.size() && i < upto; i++)
      send_bit(tx_q[i], i == pre_at);
  endtask

  task automatic tail();
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
  endtask

  initial begin
    bus.en = 1'b0;
    bus.data_bit = 1'b0;
    bus.preamble_detected = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_out", {11'd0, bus.aa_match, bus.bit_valid,
        bus.bit_out, bus.pkt_done, bus.pkt_abort,
        bus.header}, 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    // Ideal packet, 6 byte payload.
    run(BLE_ADV_AA, 16'h0600, 72, -1, 1000);
    tail();
    chk("ideal_aa_cnt", n_aa - b_aa, 1);
    chk("ideal_aa_t", 32'(snap_q[31][2]), 1);
    chk("ideal_hdr", 32'(bus.header), 32'h0600);
    chk("ideal_val_cnt", n_val - b_val, 72);
    chk("ideal_bits", mism(rx_base), 0);
    chk("ideal_val_t", 32'(snap_q[48][0]), 1);
    chk("ideal_last_val", 32'(snap_q[119][0]), 1);
    chk("ideal_done_t", 32'(snap_q[119][3]), 1);
    chk("ideal_done_cnt", n_done - b_done, 1);
    chk("ideal_abort", n_abort - b_abort, 0);

    // One AA bit flipped: still accepted.
    run(BLE_ADV_AA ^ 32'h0000_0100, 16'h0100, 32, -1, 1000);
    tail();
    chk("aa1_cnt", n_aa - b_aa, 1);
    chk("aa1_hdr", 32'(bus.header), 32'h0100);
    chk("aa1_val_cnt", n_val - b_val, 32);
    chk("aa1_bits", mism(rx_base), 0);
    chk("aa1_done", n_done - b_done, 1);

    // Two AA bits flipped: silently dropped.
    run(BLE_ADV_AA ^ 32'h8000_0001, 16'h0200, 40, -1, 1000);
    tail();
    chk("aa2_cnt", n_aa - b_aa, 0);
    chk("aa2_val", n_val - b_val, 0);
    chk("aa2_done", n_done - b_done, 0);
    chk("aa2_hdr_kept", 32'(bus.header), 32'h0100);

    // Length 0x30 exceeds the limit.
    run(BLE_ADV_AA, 16'h3000, 40, -1, 1000);
    tail();
    chk("len48_abort", n_abort - b_abort, 1);
    chk("len48_abort_t", 32'(snap_q[47][1]), 1);
    chk("len48_val", n_val - b_val, 0);
    chk("len48_done", n_done - b_done, 0);
    chk("len48_hdr", 32'(bus.header), 32'h3000);

    // Length 37 is the largest accepted.
    run(BLE_ADV_AA, 16'h2500, 320, -1, 1000);
    tail();
    chk("len37_abort", n_abort - b_abort, 0);
    chk("len37_val", n_val - b_val, 320);
    chk("len37_bits", mism(rx_base), 0);
    chk("len37_done", n_done - b_done, 1);

    // Enable toggling every cycle.
    tog = 1'b1;
    exp_gap = 2 * SR;
    run(BLE_ADV_AA, 16'h0600, 72, -1, 1000);
    tail();
    chk("tog_aa_t", 32'(snap_q[31][2]), 1);
    chk("tog_aa_cnt", n_aa - b_aa, 1);
    chk("tog_hdr", 32'(bus.header), 32'h0600);
    chk("tog_val_cnt", n_val - b_val, 72);
    chk("tog_bits", mism(rx_base), 0);
    chk("tog_done", n_done - b_done, 1);
    tog = 1'b0;
    exp_gap = SR;
    repeat (2) @(negedge clk);

    // Second detect mid-payload is ignored.
    run(BLE_ADV_AA, 16'h0200, 40, 58, 1000);
    tail();
    chk("redet_aa_cnt", n_aa - b_aa, 1);
    chk("redet_val", n_val - b_val, 40);
    chk("redet_bits", mism(rx_base), 0);
    chk("redet_done", n_done - b_done, 1);

    // Reset at payload bit 20.
    run(BLE_ADV_AA, 16'h0600, 72, -1, 68);
    @(negedge clk);
    bus.en = 1'b0;
    resetn = 1'b0;
    #1;
    chk("rst_async", {11'd0, bus.aa_match, bus.bit_valid,
        bus.bit_out, bus.pkt_done, bus.pkt_abort,
        bus.header}, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_val", n_val - b_val, 20);
    chk("rst_no_done", n_done - b_done, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    // Clean zero-length packet after reset.
    run(BLE_ADV_AA, 16'h0000, 24, -1, 1000);
    tail();
    chk("post_aa", n_aa - b_aa, 1);
    chk("post_hdr", 32'(bus.header), 32'h0000);
    chk("post_val", n_val - b_val, 24);
    chk("post_bits", mism(rx_base), 0);
    chk("post_done", n_done - b_done, 1);

    chk("overlap", n_ovl, 0);
    chk("strobe_gap", n_gap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/packet_sync.md
# packet_sync

Bit-timing and packet framing stage directly downstream of the preamble detector in the BLE receive chain. On a preamble detect it starts a mid-bit sampling strobe on the oversampled matched-filter bit stream and correlates the next 32 bits against the access address. On a match it captures the 16-bit PDU header, then streams the payload and CRC bits out with a valid strobe to the dewhitening/CRC stage.

## Interface
- SAMPLE_RATE, 16, oversampling factor (enabled cycles per bit); even, ≥4
- ACCESS_ADDR, 32'h8E89BED6, expected access address; transmitted LSB first
- AA_ERRORS, 1, maximum bit mismatches accepted in access-address compare
- MAX_LEN, 37, maximum PDU length byte accepted
- CRC_BITS, 24, trailer bits streamed after the payload
- clk  in  1  system clock
- resetn  in  1  reset; asynchronous, active-low
- en  in  1  sample-rate enable; all state advances only when en=1
- data_bit  in  1  hard-decision matched-filter output, one per enabled cycle
- preamble_detected  in  1  detect pulse from the preamble detector
- aa_match  out  1  one-cycle pulse when the access address is accepted
- header  out  16  captured PDU header, LSB = first received bit; held until next aa_match
- bit_out  out  1  payload/CRC bit
- bit_valid  out  1  one-cycle strobe qualifying bit_out
- pkt_done  out  1  one-cycle pulse after the last CRC bit
- pkt_abort  out  1  one-cycle pulse on length violation

## Operation
- States: IDLE, ACCESS, HEADER, PAYLOAD, DONE.
- IDLE: when en & preamble_detected, load the phase counter with SAMPLE_RATE/2-2, clear the bit counter, and go to ACCESS. preamble_detected is ignored in all other states.
- Phase counter: decrements on each en cycle. At 0 it produces a sample strobe and reloads SAMPLE_RATE-1. Every state except IDLE consumes one data_bit per strobe.
- ACCESS: shift sampled bits in LSB-first into a 32-bit register. On the 32nd strobe, compute the popcount of (register ^ ACCESS_ADDR).
  - If ≤ AA_ERRORS: pulse aa_match and go to HEADER.
  - Otherwise: return to IDLE silently.
- HEADER: capture 16 bits LSB-first. On the 16th bit, update the header output; length = header[15:8].
  - If length > MAX_LEN: pulse pkt_abort and go to IDLE.
  - Otherwise: go to PAYLOAD with remaining = length*8 + CRC_BITS. Width is 12 bits, with no overflow for MAX_LEN ≤ 255.
- PAYLOAD: on each strobe, drive bit_out = data_bit with bit_valid = 1 and decrement remaining. When the last bit is issued, go to DONE.
  - A length of 0 still streams the CRC_BITS trailer bits.
- DONE: pulse pkt_done for one cycle, then go to IDLE. While in DONE, a preamble_detected that cycle is ignored.
- Reset mid-packet: all state and outputs return to reset values immediately; no pulse is emitted.

## Timing
- Reset values: all outputs 0; header = 16'h0; state = IDLE.
- First sample strobe occurs SAMPLE_RATE/2-1 enabled cycles after the detect cycle. This compensates for the detector's one-stage pipeline and lands at mid-bit of access-address bit 0.
- Subsequent strobes are exactly SAMPLE_RATE enabled cycles apart.
- Output timing is registered: aa_match, pkt_abort, and bit_valid assert in the cycle following their deciding strobe.
  - pkt_done asserts one cycle after the final bit_valid.
- en = 0 freezes the counters and state; single-cycle pulses still last exactly one clk.
- bit_valid is never asserted in the same cycle as aa_match or pkt_abort.

## Structure
- Shared package ble_rx_pkg holds:
  - the state enum (pkt_state_t)
  - the BLE_ADV_AA constant (32'h8E89BED6)
  - the AA_LEN = 32 and HDR_LEN = 16 localparams
- One sub-module, bit_sampler, owns the phase counter and the strobe: inputs en, start; output strobe.
- The FSM, shift registers, and popcount remain in packet_sync.

## Test plan
- Ideal packet (SAMPLE_RATE 16; preamble, AA 0x8E89BED6, header 0x0600, 6 payload bytes, 24 CRC bits) -> aa_match once, header = 16'h0600, exactly 72 bit_valid strobes matching the sent bits, then pkt_done.
- AA with one flipped bit -> aa_match. AA with two flipped bits -> no aa_match, return to IDLE, no further outputs.
- Header length 0x30 (48 > 37) -> pkt_abort one cycle after the 16th header strobe, zero bit_valid.
- en toggling 1/0 every cycle during an ideal packet -> identical bit sequence and counts; strobes spaced 32 clk apart.
- A second preamble_detected pulse mid-PAYLOAD -> ignored; the packet completes normally.
- resetn asserted at payload bit 20 -> all outputs 0 immediately; a subsequent clean packet decodes correctly.
